// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_monitor
// Purpose  : Receive-side checker for a VGA stream (HS/VS/BLANK/RGB 3:3:2).
//            Measures active width/height per frame, signs the active pixels,
//            flags geometry errors and reports lock / loss of signal.
// Options  : VGA_MON_CRC_EN - FRAME_SUM is CRC-16-CCITT (0x1021, init 0xFFFF,
//            MSB first); otherwise an additive 16-bit sum of the pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_NEG    = 1'b1,
  parameter int LOCK_FRAMES = 2,
  parameter int WDOG_BITS   = 20
) (
  input  logic        CLK_25MHz,
  input  logic        RESET,
  input  logic        HS,
  input  logic        VS,
  input  logic        BLANK,
  input  logic [2:0]  RED,
  input  logic [2:0]  GREEN,
  input  logic [1:0]  BLUE,
  output logic        FRAME_VALID,
  output logic [10:0] ACT_W,
  output logic [9:0]  ACT_H,
  output logic [15:0] FRAME_SUM,
  output logic [2:0]  ERR,
  output logic        LOCKED,
  output logic        NO_SIGNAL
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] c_h_active    = 11'(H_ACTIVE);
  localparam logic [9:0]  c_v_active    = 10'(V_ACTIVE);
  localparam logic [2:0]  c_lock_frames = 3'(LOCK_FRAMES);

`ifdef VGA_MON_CRC_EN
  localparam logic [15:0] c_sum_init = 16'hFFFF;

  // One byte of CRC-16-CCITT: fold the byte into the top, then eight shifts.
  function automatic logic [15:0] sum_step(input logic [15:0] acc, input logic [7:0] px);
    logic [15:0] crc;
    crc = acc ^ {px, 8'h00};
    for (int i = 0; i < 8; i++) begin
      crc = crc[15] ? ({crc[14:0], 1'b0} ^ 16'h1021) : {crc[14:0], 1'b0};
    end
    return crc;
  endfunction
`else
  localparam logic [15:0] c_sum_init = 16'h0000;

  // Modulo-2^16 additive signature; overflow wraps silently.
  function automatic logic [15:0] sum_step(input logic [15:0] acc, input logic [7:0] px);
    return acc + {8'h00, px};
  endfunction
`endif

  // HS carries no information the monitor needs: BLANK alone delimits lines.
  logic unused_hs;
  assign unused_hs = HS;

  logic                 vs_act_q, vs_act_d, vs_prev_q, vs_prev_d;
  logic                 blank_q, blank_d, blank_prev_q, blank_prev_d;
  logic [7:0]           pix_q, pix_d;
  logic [10:0]          line_cnt_q, line_cnt_d, wref_q, wref_d;
  logic [9:0]           lines_q, lines_d;
  logic                 mism_q, mism_d;
  logic [15:0]          sum_q, sum_d;
  logic [WDOG_BITS-1:0] wdog_q, wdog_d;
  logic [2:0]           good_cnt_q, good_cnt_d;
  state_t               state_q, state_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [10:0]          act_w_q, act_w_d;
  logic [9:0]           act_h_q, act_h_d;
  logic [15:0]          frame_sum_q, frame_sum_d;
  logic [2:0]           err_q, err_d;
  logic                 no_signal_q, no_signal_d;

  logic        vs_start, act_end, close_line, wdog_expire;
  logic [10:0] wref_c;
  logic [9:0]  lines_c;
  logic        mism_c;
  logic [2:0]  err_c, good_next;
  logic [15:0] sum_upd;

  // Capture pins once; keep a delayed copy of VS/BLANK for edge detection.
  always_comb begin
    vs_act_d     = SYNC_NEG ? ~VS : VS;
    vs_prev_d    = vs_act_q;
    blank_d      = BLANK;
    blank_prev_d = blank_q;
    pix_d        = {RED, GREEN, BLUE};
  end

  assign vs_start    = vs_act_q & ~vs_prev_q;
  assign act_end     = blank_q & ~blank_prev_q;
  assign wdog_expire = (wdog_q == '1) & ~vs_start;

  // Line/frame measurement: closing a line updates width reference, mismatch
  // and line count; vs_start restarts the frame with the coincident pixel.
  always_comb begin
    close_line = (act_end | (vs_start & ~blank_q)) & (line_cnt_q != '0);
    wref_c     = wref_q;
    lines_c    = lines_q;
    mism_c     = mism_q;
    if (close_line) begin
      if (lines_q == '0) begin
        wref_c = line_cnt_q;
      end else if (line_cnt_q != wref_q) begin
        mism_c = 1'b1;
      end
      if (lines_q != '1) begin
        lines_c = lines_q + 10'd1;
      end
    end
    err_c   = {lines_c != c_v_active, wref_c != c_h_active, mism_c};
    sum_upd = sum_step(vs_start ? c_sum_init : sum_q, pix_q);

    line_cnt_d = line_cnt_q;
    wref_d     = wref_c;
    lines_d    = lines_c;
    mism_d     = mism_c;
    sum_d      = blank_q ? sum_q : sum_upd;
    if (vs_start) begin
      line_cnt_d = blank_q ? 11'd0 : 11'd1;
      wref_d     = '0;
      lines_d    = '0;
      mism_d     = 1'b0;
      sum_d      = blank_q ? c_sum_init : sum_upd;
    end else if (close_line) begin
      line_cnt_d = '0;
    end else if (!blank_q && line_cnt_q != '1) begin
      line_cnt_d = line_cnt_q + 11'd1;
    end
  end

  // Lock FSM, frame result publication and no-VS watchdog.
  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    frame_valid_d = 1'b0;
    act_w_d       = act_w_q;
    act_h_d       = act_h_q;
    frame_sum_d   = frame_sum_q;
    err_d         = err_q;
    no_signal_d   = no_signal_q;
    good_next     = (good_cnt_q == '1) ? good_cnt_q : good_cnt_q + 3'd1;
    wdog_d        = vs_start ? '0 : ((wdog_q == '1) ? wdog_q : wdog_q + WDOG_BITS'(1));

    if (wdog_expire) begin
      state_d     = ST_SEARCH;
      good_cnt_d  = '0;
      no_signal_d = 1'b1;
    end else if (vs_start) begin
      no_signal_d = 1'b0;
      if (state_q == ST_SEARCH) begin
        // The frame in progress was entered mid-way: discard it.
        state_d    = ST_MEASURE;
        good_cnt_d = '0;
      end else begin
        frame_valid_d = 1'b1;
        act_w_d       = wref_c;
        act_h_d       = lines_c;
        frame_sum_d   = sum_q;
        err_d         = err_c;
        if (err_c == '0) begin
          good_cnt_d = good_next;
          if (good_next >= c_lock_frames) begin
            state_d = ST_LOCKED;
          end
        end else begin
          good_cnt_d = '0;
          state_d    = ST_MEASURE;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      vs_act_q      <= 1'b0;
      vs_prev_q     <= 1'b0;
      blank_q       <= 1'b1;
      blank_prev_q  <= 1'b1;
      pix_q         <= '0;
      line_cnt_q    <= '0;
      wref_q        <= '0;
      lines_q       <= '0;
      mism_q        <= 1'b0;
      sum_q         <= c_sum_init;
      wdog_q        <= '0;
      good_cnt_q    <= '0;
      state_q       <= ST_SEARCH;
      frame_valid_q <= 1'b0;
      act_w_q       <= '0;
      act_h_q       <= '0;
      frame_sum_q   <= '0;
      err_q         <= '0;
      no_signal_q   <= 1'b0;
    end else begin
      vs_act_q      <= vs_act_d;
      vs_prev_q     <= vs_prev_d;
      blank_q       <= blank_d;
      blank_prev_q  <= blank_prev_d;
      pix_q         <= pix_d;
      line_cnt_q    <= line_cnt_d;
      wref_q        <= wref_d;
      lines_q       <= lines_d;
      mism_q        <= mism_d;
      sum_q         <= sum_d;
      wdog_q        <= wdog_d;
      good_cnt_q    <= good_cnt_d;
      state_q       <= state_d;
      frame_valid_q <= frame_valid_d;
      act_w_q       <= act_w_d;
      act_h_q       <= act_h_d;
      frame_sum_q   <= frame_sum_d;
      err_q         <= err_d;
      no_signal_q   <= no_signal_d;
    end
  end

  assign FRAME_VALID = frame_valid_q;
  assign ACT_W       = act_w_q;
  assign ACT_H       = act_h_q;
  assign FRAME_SUM   = frame_sum_q;
  assign ERR         = err_q;
  assign LOCKED      = (state_q == ST_LOCKED);
  assign NO_SIGNAL   = no_signal_q;

endmodule
`default_nettype wire
